fifo_stream_drain: RTL and testbench

Read-side drain stage placed directly downstream of the synchronous FIFO. It issues `rd_en` pulses to the FIFO, absorbs the FIFO's one-cycle registered read latency in a 2-entry output buffer, and presents the data as a valid/ready stream to the next stage at full throughput. It also latches FIFO underflow events into a sticky error flag for software or bench inspection.

---
 rtl/fifo_stream_drain.sv | 89 ++++++++
 tb/tb_fifo_stream_drain.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_drain.sv
// Read-side drain: turns FIFO rd_en/registered data into a valid/ready stream.
// Optional transfer counter enabled by defining DRAIN_CNT_EN.
module fifo_stream_drain #(
   parameter int DATA_WIDTH = 16
`ifdef DRAIN_CNT_EN
   ,
   parameter int CNT_WIDTH = 16
`endif
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data_out,
   input  logic                  fifo_underflow,
   output logic                  fifo_rd_en,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   input  logic                  m_ready,
   input  logic                  clr_err,
   output logic                  err_underflow
`ifdef DRAIN_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]  xfer_count
`endif
);

   logic [1:0]            occ_q;
   logic [1:0]            occ_d;
   logic                  inflight_q;
   logic                  head_q;
   logic                  tail_q;
   logic                  err_q;
   logic                  err_d;
   logic [DATA_WIDTH-1:0] mem_q [2];
   logic                  pop;
   logic [2:0]            slots;

   assign m_valid = (occ_q != 2'd0);
   assign m_data  = mem_q[head_q];
   assign pop     = m_valid & m_ready;

   // Words owned after this edge: buffered plus in flight, minus the one leaving.
   assign slots = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign occ_d = slots[1:0];

   assign fifo_rd_en = rst_n & enable & ~fifo_empty & (slots < 3'd2);

   assign err_d         = fifo_underflow | (err_q & ~clr_err);
   assign err_underflow = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q      <= 2'd0;
         inflight_q <= 1'b0;
         head_q     <= 1'b0;
         tail_q     <= 1'b0;
         err_q      <= 1'b0;
         mem_q[0]   <= '0;
         mem_q[1]   <= '0;
      end else begin
         occ_q      <= occ_d;
         inflight_q <= fifo_rd_en;
         err_q      <= err_d;
         if (inflight_q) begin
            mem_q[tail_q] <= fifo_data_out;
            tail_q        <= ~tail_q;
         end
         if (pop) begin
            head_q <= ~head_q;
         end
      end
   end

`ifdef DRAIN_CNT_EN
   logic [CNT_WIDTH-1:0] cnt_q;

   assign xfer_count = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (pop) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain: FIFO model, stream scoreboard, vector table,
// directed corner sequences and randomized traffic.
module tb_fifo_stream_drain;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          enable = 1'b0;
   logic          fifo_empty = 1'b1;
   logic [DW-1:0] fifo_data_out = '0;
   logic          fifo_underflow = 1'b0;
   logic          m_ready = 1'b0;
   logic          clr_err = 1'b0;
   logic          fifo_rd_en;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          err_underflow;
`ifdef DRAIN_CNT_EN
   logic [3:0]    xfer_count;
`endif

   fifo_stream_drain #(
      .DATA_WIDTH(DW)
`ifdef DRAIN_CNT_EN
      , .CNT_WIDTH(4)
`endif
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .fifo_empty    (fifo_empty),
      .fifo_data_out (fifo_data_out),
      .fifo_underflow(fifo_underflow),
      .fifo_rd_en    (fifo_rd_en),
      .m_valid       (m_valid),
      .m_data        (m_data),
      .m_ready       (m_ready),
      .clr_err       (clr_err),
      .err_underflow (err_underflow)
`ifdef DRAIN_CNT_EN
      , .xfer_count  (xfer_count)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] sb_q[$];
   int  reads, caps, pops;
   bit  prev_rd, mon_en, hold_prev;
   logic [DW-1:0] hold_data;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Upstream FIFO: registered read data, empty flag updates at the edge.
   always @(posedge clk) begin
      if (fifo_rd_en && fifo_q.size() > 0) begin
         fifo_data_out <= fifo_q[0];
         sb_q.push_back(fifo_q[0]);
         void'(fifo_q.pop_front());
      end
      fifo_empty <= (fifo_q.size() == 0);
   end

   // Reference: words owned = reads - pops; visible = captured - pops.
   always @(negedge clk) begin
      if (mon_en) begin
         bit p;
         logic [DW-1:0] w;
         p = m_valid && m_ready;
         chk("rd_en", fifo_rd_en,
             enable && !fifo_empty && (reads - pops - int'(p)) < 2);
         chk("m_valid", m_valid, (caps - pops) > 0);
         chk("cap_at_full", dut.inflight_q && dut.occ_q == 2'd2 && !p, 0);
         if (hold_prev) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, hold_data);
         end
         if (p) begin
            if (sb_q.size() == 0) begin
               chk("order_empty", m_data, 32'hdead_beef);
            end else begin
               w = sb_q.pop_front();
               chk("order", m_data, w);
            end
         end
         hold_prev = m_valid && !m_ready;
         hold_data = m_data;
         pops += int'(p);
         caps += int'(prev_rd);
         prev_rd = fifo_rd_en;
         reads += int'(fifo_rd_en);
      end
   end

   task automatic do_reset();
      mon_en = 0;
      rst_n = 1'b0;
      #1;
      chk("rst_valid", m_valid, 0);
      chk("rst_data", m_data, 0);
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_err", err_underflow, 0);
`ifdef DRAIN_CNT_EN
      chk("rst_count", xfer_count, 0);
`endif
      enable = 0;
      m_ready = 0;
      fifo_underflow = 0;
      clr_err = 0;
      fifo_q.delete();
      sb_q.delete();
      reads = 0;
      caps = 0;
      pops = 0;
      prev_rd = 0;
      hold_prev = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      mon_en = 1;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit          en;
      bit          rdy;
      bit          uf;
      bit          clr;
      bit          rd;
      bit          vld;
      bit          chkd;
      logic [15:0] d;
      bit          err;
   } vec_t;

   vec_t tbl[14];

   initial begin
      int n, first, last, got;
      bit seen;

      tbl[0]  = '{1, 1, 0, 0, 1, 0, 0, 16'h0000, 0};
      tbl[1]  = '{1, 1, 0, 0, 1, 0, 0, 16'h0000, 0};
      tbl[2]  = '{1, 1, 0, 0, 0, 1, 1, 16'h1111, 0};
      tbl[3]  = '{1, 1, 0, 0, 0, 1, 1, 16'h2222, 0};
      tbl[4]  = '{1, 1, 0, 0, 0, 0, 0, 16'h0000, 0};
      tbl[5]  = '{0, 0, 1, 0, 0, 0, 0, 16'h0000, 0};
      tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 16'h0000, 1};
      tbl[7]  = '{0, 0, 0, 1, 0, 0, 0, 16'h0000, 1};
      tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 16'h0000, 0};
      tbl[9]  = '{0, 0, 1, 1, 0, 0, 0, 16'h0000, 0};
      tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 16'h0000, 1};
      tbl[11] = '{0, 0, 1, 0, 0, 0, 0, 16'h0000, 1};
      tbl[12] = '{0, 0, 0, 1, 0, 0, 0, 16'h0000, 1};
      tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 16'h0000, 0};

      #2;
      do_reset();

      // Basic read followed by the underflow latch sequence.
      fifo_q.push_back(16'h1111);
      fifo_q.push_back(16'h2222);
      cyc();
      for (int i = 0; i < 14; i++) begin
         enable = tbl[i].en;
         m_ready = tbl[i].rdy;
         fifo_underflow = tbl[i].uf;
         clr_err = tbl[i].clr;
         @(negedge clk);
         chk($sformatf("tbl%0d_rd", i), fifo_rd_en, tbl[i].rd);
         chk($sformatf("tbl%0d_vld", i), m_valid, tbl[i].vld);
         chk($sformatf("tbl%0d_err", i), err_underflow, tbl[i].err);
         if (tbl[i].chkd)
            chk($sformatf("tbl%0d_data", i), m_data, tbl[i].d);
         cyc();
      end
      fifo_underflow = 0;
      clr_err = 0;

      // Backpressure: only two words pulled, then a gapless drain.
      do_reset();
      for (int i = 0; i < 8; i++) fifo_q.push_back(16'(i));
      cyc();
      enable = 1;
      m_ready = 0;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n += int'(fifo_rd_en);
         cyc();
      end
      chk("bp_reads", n, 2);
      chk("bp_occ", dut.occ_q, 2);
      chk("bp_valid", m_valid, 1);
      chk("bp_data", m_data, 16'h0000);
      m_ready = 1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("bp_gap%0d", i), m_valid, 1);
         chk($sformatf("bp_word%0d", i), m_data, 16'(i));
         cyc();
      end
      @(negedge clk);
      chk("bp_done", m_valid, 0);
      cyc();

      // Enable drops right after a read: in-flight word still arrives.
      do_reset();
      for (int i = 0; i < 5; i++) fifo_q.push_back(16'hA0 + 16'(i));
      cyc();
      enable = 1;
      m_ready = 0;
      @(negedge clk);
      chk("en_first_rd", fifo_rd_en, 1);
      cyc();
      enable = 0;
      n = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n += int'(fifo_rd_en);
         cyc();
      end
      chk("en_no_reads", n, 0);
      chk("en_valid", m_valid, 1);
      chk("en_data", m_data, 16'h00A0);
      m_ready = 1;
      cyc();
      @(negedge clk);
      chk("en_drained", m_valid, 0);
      cyc();

      // Reset mid-stream with a full buffer, then fresh data only.
      do_reset();
      for (int i = 0; i < 8; i++) fifo_q.push_back(16'h30 + 16'(i));
      cyc();
      enable = 1;
      m_ready = 0;
      repeat (4) cyc();
      chk("mid_occ", dut.occ_q, 2);
      #2;
      do_reset();
      for (int i = 0; i < 4; i++) fifo_q.push_back(16'h50 + 16'(i));
      cyc();
      enable = 1;
      m_ready = 1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (m_valid && !seen) begin
            seen = 1;
            chk("mid_first_word", m_data, 16'h0050);
         end
         cyc();
      end
      chk("mid_seen", seen, 1);

      // Throughput: 20 queued words leave on 20 consecutive cycles.
      do_reset();
      for (int i = 0; i < 20; i++) fifo_q.push_back(16'($urandom));
      cyc();
      enable = 1;
      m_ready = 1;
      n = 0;
      first = -1;
      last = -1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (m_valid) begin
            n++;
            if (first < 0) first = i;
            last = i;
         end
         cyc();
      end
      chk("tp_count", n, 20);
      chk("tp_span", last - first + 1, 20);
      chk("tp_latency", first, 2);

`ifdef DRAIN_CNT_EN
      // Counter wraps at 16 with a 4-bit width.
      do_reset();
      for (int i = 0; i < 17; i++) fifo_q.push_back(16'(i));
      cyc();
      enable = 1;
      m_ready = 1;
      got = 0;
      for (int i = 0; i < 40 && got < 17; i++) begin
         @(negedge clk);
         got += int'(m_valid && m_ready);
         cyc();
      end
      chk("cnt_pops", got, 17);
      chk("cnt_wrap", xfer_count, 1);
`endif

      // Randomized traffic against the scoreboard.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         enable = ($urandom_range(0, 9) < 8);
         m_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 1) == 1 && fifo_q.size() < 16)
            fifo_q.push_back(16'($urandom));
         cyc();
      end
      enable = 0;
      m_ready = 1;
      repeat (40) cyc();
      chk("rand_all_out", pops, reads);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
